// File: rtl/fht_but_array_bfp_pkg.sv
// Shared constants and permutation encoding for the block-floating-point FHT butterfly array.
package fht_but_array_bfp_pkg;

    localparam int D_BIT_DEF = 17;
    localparam int W_BIT_DEF = 12;
    localparam int S_BIT_DEF = 4;
    localparam int PIPE_LAT  = 4;

    typedef enum logic [1:0] {
        PERM_INTERLEAVE = 2'd0,
        PERM_SWAP       = 2'd1,
        PERM_LAST       = 2'd2
    } perm_mode_t;

    // Twiddles are Q(W_BIT-2): the product is renormalised by this many bits.
    function automatic int q_shift(input int w_bit);
        return w_bit - 2;
    endfunction

    function automatic perm_mode_t perm_sel(input logic st_last, input logic second_part);
        if (st_last)
            return PERM_LAST;
        else if (second_part)
            return PERM_SWAP;
        return PERM_INTERLEAVE;
    endfunction

endpackage

// File: rtl/fht_but_array_bfp_lane.sv
// One radix-2 butterfly lane: operand register, product register, sum/scale/saturate register.
module fht_bfp_lane
    import fht_but_array_bfp_pkg::*;
#(
    parameter int D_BIT = D_BIT_DEF,
    parameter int W_BIT = W_BIT_DEF
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    i_vld,
    input  logic                    i_vld_p0,
    input  logic                    i_vld_p1,
    input  logic                    i_scale,
    input  logic signed [D_BIT-1:0] i_x0,
    input  logic signed [D_BIT-1:0] i_x1,
    input  logic signed [D_BIT-1:0] i_x2,
    input  logic signed [W_BIT-1:0] i_sin,
    input  logic signed [W_BIT-1:0] i_cos,
    output logic signed [D_BIT-1:0] o_y0,
    output logic signed [D_BIT-1:0] o_y1,
    output logic                    o_sat
);

    localparam int PW = D_BIT + W_BIT;
    localparam int SW = PW + 2;
    localparam int QS = q_shift(W_BIT);

    function automatic logic is_sat(input logic signed [SW-1:0] v);
        return !((&v[SW-1:D_BIT-1]) || !(|v[SW-1:D_BIT-1]));
    endfunction

    function automatic logic signed [D_BIT-1:0] sat_d(input logic signed [SW-1:0] v);
        if (!is_sat(v))
            return v[D_BIT-1:0];
        return v[SW-1] ? {1'b1, {(D_BIT-1){1'b0}}} : {1'b0, {(D_BIT-1){1'b1}}};
    endfunction

    logic signed [D_BIT-1:0] r_x0_p0, r_x1_p0, r_x2_p0, r_x0_p1;
    logic signed [W_BIT-1:0] r_sin_p0, r_cos_p0;
    logic signed [PW-1:0]    r_pc_p1, r_ps_p1;
    logic                    r_scale_p0, r_scale_p1;
    logic signed [D_BIT-1:0] r_y0_p2, r_y1_p2;
    logic                    r_sat_p2;
    logic signed [SW-1:0]    w_t, w_y0, w_y1;

    always_comb begin
        w_t  = (SW'(r_pc_p1) + SW'(r_ps_p1)) >>> QS;
        w_y0 = SW'(r_x0_p1) + w_t;
        w_y1 = SW'(r_x0_p1) - w_t;
        if (r_scale_p1) begin
            w_y0 = w_y0 >>> 1;
            w_y1 = w_y1 >>> 1;
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_x0_p0    <= '0;
            r_x1_p0    <= '0;
            r_x2_p0    <= '0;
            r_sin_p0   <= '0;
            r_cos_p0   <= '0;
            r_scale_p0 <= 1'b0;
            r_x0_p1    <= '0;
            r_pc_p1    <= '0;
            r_ps_p1    <= '0;
            r_scale_p1 <= 1'b0;
            r_y0_p2    <= '0;
            r_y1_p2    <= '0;
            r_sat_p2   <= 1'b0;
        end else begin
            // stage 1: operands and twiddles
            if (i_vld) begin
                r_x0_p0    <= i_x0;
                r_x1_p0    <= i_x1;
                r_x2_p0    <= i_x2;
                r_sin_p0   <= i_sin;
                r_cos_p0   <= i_cos;
                r_scale_p0 <= i_scale;
            end
            // stage 2: full-precision products
            if (i_vld_p0) begin
                r_x0_p1    <= r_x0_p0;
                r_pc_p1    <= PW'(r_x1_p0) * PW'(r_cos_p0);
                r_ps_p1    <= PW'(r_x2_p0) * PW'(r_sin_p0);
                r_scale_p1 <= r_scale_p0;
            end
            // stage 3: sum, optional halving, saturation
            if (i_vld_p1) begin
                r_y0_p2  <= sat_d(w_y0);
                r_y1_p2  <= sat_d(w_y1);
                r_sat_p2 <= is_sat(w_y0) | is_sat(w_y1);
            end
        end
    end

    assign o_y0  = r_y0_p2;
    assign o_y1  = r_y1_p2;
    assign o_sat = r_sat_p2;

endmodule

// File: rtl/fht_but_array_bfp.sv
// FHT butterfly array with block-floating-point stage scaling and output permutation.
module fht_but_array_bfp
    import fht_but_array_bfp_pkg::*;
#(
    parameter int D_BIT  = D_BIT_DEF,
    parameter int W_BIT  = W_BIT_DEF,
    parameter int N_LANE = 2,
    parameter int S_BIT  = S_BIT_DEF
) (
    input  logic                       iCLK,
    input  logic                       iRESET,
    input  logic                       iVALID,
    input  logic                       iNEW_STAGE,
    input  logic                       iST_ZERO,
    input  logic                       iST_LAST,
    input  logic                       i2ND_PART_SUBSEC,
    input  logic [3*N_LANE*D_BIT-1:0]  iX,
    input  logic [N_LANE*W_BIT-1:0]    iSIN,
    input  logic [N_LANE*W_BIT-1:0]    iCOS,
    output logic                       oVALID,
    output logic [2*N_LANE*D_BIT-1:0]  oY,
    output logic [S_BIT-1:0]           oSHIFT,
    output logic                       oOVF
);

    localparam int N_OUT = 2 * N_LANE;

    logic [PIPE_LAT-1:0]     r_vld;
    perm_mode_t              r_mode_p0, r_mode_p1, r_mode_p2;
    logic                    r_scale, r_grow, r_ovf;
    logic [S_BIT-1:0]        r_shift;
    logic signed [D_BIT-1:0] w_y0 [N_LANE];
    logic signed [D_BIT-1:0] w_y1 [N_LANE];
    logic [N_LANE-1:0]       w_sat, w_big;
    logic signed [D_BIT-1:0] w_perm [N_OUT];
    logic signed [D_BIT-1:0] r_y_p3 [N_OUT];
    logic                    w_sat_evt, w_grow_evt, w_grow_any;

    for (genvar k = 0; k < N_LANE; k++) begin : g_lane
        fht_bfp_lane #(.D_BIT(D_BIT), .W_BIT(W_BIT)) u_lane (
            .iCLK     (iCLK),
            .iRESET   (iRESET),
            .i_vld    (iVALID),
            .i_vld_p0 (r_vld[0]),
            .i_vld_p1 (r_vld[1]),
            .i_scale  (r_scale),
            .i_x0     ($signed(iX[(3*k)*D_BIT +: D_BIT])),
            .i_x1     ($signed(iX[(3*k+1)*D_BIT +: D_BIT])),
            .i_x2     ($signed(iX[(3*k+2)*D_BIT +: D_BIT])),
            .i_sin    ($signed(iSIN[k*W_BIT +: W_BIT])),
            .i_cos    ($signed(iCOS[k*W_BIT +: W_BIT])),
            .o_y0     (w_y0[k]),
            .o_y1     (w_y1[k]),
            .o_sat    (w_sat[k])
        );
        // Top two bits differing means the value no longer fits with one bit of headroom.
        assign w_big[k] = (w_y0[k][D_BIT-1] ^ w_y0[k][D_BIT-2]) |
                          (w_y1[k][D_BIT-1] ^ w_y1[k][D_BIT-2]);
    end

    for (genvar i = 0; i < N_OUT; i++) begin : g_out
        assign oY[i*D_BIT +: D_BIT] = r_y_p3[i];
    end

    assign w_sat_evt  = r_vld[2] & (|w_sat);
    assign w_grow_evt = r_vld[2] & (|w_big);
    assign w_grow_any = r_grow | w_grow_evt;

    always_comb begin
        for (int i = 0; i < N_OUT; i++)
            w_perm[i] = '0;
        for (int j = 0; j < N_LANE / 2; j++) begin
            case (r_mode_p2)
                PERM_LAST: begin
                    w_perm[4*j]   = w_y0[2*j];
                    w_perm[4*j+1] = w_y1[2*j];
                    w_perm[4*j+2] = w_y0[2*j+1];
                    w_perm[4*j+3] = w_y1[2*j+1];
                end
                PERM_SWAP: begin
                    w_perm[4*j]   = w_y0[2*j+1];
                    w_perm[4*j+1] = w_y0[2*j];
                    w_perm[4*j+2] = w_y1[2*j+1];
                    w_perm[4*j+3] = w_y1[2*j];
                end
                default: begin
                    w_perm[4*j]   = w_y0[2*j];
                    w_perm[4*j+1] = w_y0[2*j+1];
                    w_perm[4*j+2] = w_y1[2*j];
                    w_perm[4*j+3] = w_y1[2*j+1];
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_vld     <= '0;
            r_mode_p0 <= PERM_INTERLEAVE;
            r_mode_p1 <= PERM_INTERLEAVE;
            r_mode_p2 <= PERM_INTERLEAVE;
            for (int i = 0; i < N_OUT; i++)
                r_y_p3[i] <= '0;
        end else begin
            r_vld <= {r_vld[PIPE_LAT-2:0], iVALID};
            if (iVALID)
                r_mode_p0 <= perm_sel(iST_LAST, i2ND_PART_SUBSEC);
            if (r_vld[0])
                r_mode_p1 <= r_mode_p0;
            if (r_vld[1])
                r_mode_p2 <= r_mode_p1;
            // stage 4: permutation register
            if (r_vld[2])
                for (int i = 0; i < N_OUT; i++)
                    r_y_p3[i] <= w_perm[i];
        end
    end

    // A growth event coincident with iNEW_STAGE is credited to the stage that is ending.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_scale <= 1'b0;
            r_grow  <= 1'b0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
        end else if (iNEW_STAGE && iST_ZERO) begin
            r_scale <= 1'b0;
            r_grow  <= 1'b0;
            r_shift <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_ovf <= r_ovf | w_sat_evt;
            if (iNEW_STAGE) begin
                r_scale <= w_grow_any;
                r_grow  <= 1'b0;
                if (w_grow_any && (r_shift != {S_BIT{1'b1}}))
                    r_shift <= r_shift + S_BIT'(1);
            end else begin
                r_grow <= w_grow_any;
            end
        end
    end

    assign oVALID = r_vld[PIPE_LAT-1];
    assign oSHIFT = r_shift;
    assign oOVF   = r_ovf;

endmodule

// File: tb/tb_fht_but_array_bfp.sv
// Directed plus randomized bench for fht_but_array_bfp against an arithmetic reference model.
module tb_fht_but_array_bfp;

    localparam int D = 17;
    localparam int W = 12;
    localparam int N = 2;
    localparam int S = 4;
    localparam int HI = (1 << (D-1)) - 1;
    localparam int LO = -(1 << (D-1));

    logic             iCLK = 1'b0;
    logic             iRESET = 1'b0;
    logic             iVALID = 1'b0;
    logic             iNEW_STAGE = 1'b0;
    logic             iST_ZERO = 1'b0;
    logic             iST_LAST = 1'b0;
    logic             i2ND_PART_SUBSEC = 1'b0;
    logic [3*N*D-1:0] iX = '0;
    logic [N*W-1:0]   iSIN = '0;
    logic [N*W-1:0]   iCOS = '0;
    logic             oVALID;
    logic [2*N*D-1:0] oY;
    logic [S-1:0]     oSHIFT;
    logic             oOVF;

    always #5 iCLK = ~iCLK;

    fht_but_array_bfp #(.D_BIT(D), .W_BIT(W), .N_LANE(N), .S_BIT(S)) dut (
        .iCLK             (iCLK),
        .iRESET           (iRESET),
        .iVALID           (iVALID),
        .iNEW_STAGE       (iNEW_STAGE),
        .iST_ZERO         (iST_ZERO),
        .iST_LAST         (iST_LAST),
        .i2ND_PART_SUBSEC (i2ND_PART_SUBSEC),
        .iX               (iX),
        .iSIN             (iSIN),
        .iCOS             (iCOS),
        .oVALID           (oVALID),
        .oY               (oY),
        .oSHIFT           (oSHIFT),
        .oOVF             (oOVF)
    );

    typedef struct {
        logic [2*N*D-1:0] y;
        bit               sat;
        bit               grow;
        int               due;
    } samp_t;

    int               errors = 0;
    int               checks = 0;
    int               tick_no = 0;
    int               x0 [N], x1 [N], x2 [N], cs [N], sn [N];
    samp_t            pend [$];
    bit               m_scale, m_grow, m_ovf, m_vld;
    int               m_shift;
    logic [2*N*D-1:0] m_y;

    function automatic longint fdiv(input longint v, input longint d);
        if (v >= 0)
            return v / d;
        return -((-v + d - 1) / d);
    endfunction

    function automatic logic [2*N*D-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [2*N*D-1:0] r;
        int v [4];
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        for (int i = 0; i < 4; i++)
            r[i*D +: D] = v[i][D-1:0];
        return r;
    endfunction

    // Expected lane results from the arithmetic definition, then the pairwise output ordering.
    function automatic samp_t model_sample();
        samp_t  s;
        longint ya [N][2];
        longint t, v, c;
        int     ln [4], yi [4], a, idx;
        logic [63:0] bits;
        s.sat  = 0;
        s.grow = 0;
        s.due  = 0;
        s.y    = '0;
        for (int k = 0; k < N; k++) begin
            t = fdiv(longint'(x1[k]) * cs[k] + longint'(x2[k]) * sn[k], 1 << (W-2));
            for (int h = 0; h < 2; h++) begin
                v = (h == 0) ? x0[k] + t : x0[k] - t;
                if (m_scale)
                    v = fdiv(v, 2);
                c = (v > HI) ? HI : (v < LO) ? LO : v;
                if (c != v)
                    s.sat = 1;
                if (c >= (1 << (D-2)) || c < -(1 << (D-2)))
                    s.grow = 1;
                ya[k][h] = c;
            end
        end
        for (int j = 0; j < N/2; j++) begin
            a = 2*j;
            if (iST_LAST) begin
                ln = '{a, a, a+1, a+1}; yi = '{0, 1, 0, 1};
            end else if (i2ND_PART_SUBSEC) begin
                ln = '{a+1, a, a+1, a}; yi = '{0, 0, 1, 1};
            end else begin
                ln = '{a, a+1, a, a+1}; yi = '{0, 0, 1, 1};
            end
            for (int i = 0; i < 4; i++) begin
                idx  = 4*j + i;
                bits = ya[ln[i]][yi[i]];
                s.y[idx*D +: D] = bits[D-1:0];
            end
        end
        return s;
    endfunction

    task automatic model_clear();
        pend.delete();
        m_scale = 0; m_grow = 0; m_ovf = 0; m_vld = 0; m_shift = 0; m_y = '0;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".oVALID"}, 128'(oVALID), 128'(m_vld));
        chk({tag, ".oY"}, 128'(oY), 128'(m_y));
        chk({tag, ".oSHIFT"}, 128'(oSHIFT), 128'(m_shift));
        chk({tag, ".oOVF"}, 128'(oOVF), 128'(m_ovf));
    endtask

    task automatic set_lane(input int k, input int a0, input int a1, input int a2,
                            input int c, input int s);
        x0[k] = a0; x1[k] = a1; x2[k] = a2; cs[k] = c; sn[k] = s;
    endtask

    task automatic tick(input string tag);
        samp_t s, o;
        bit    pushv, eg, es;
        for (int k = 0; k < N; k++) begin
            iX[(3*k)*D +: D]   = x0[k][D-1:0];
            iX[(3*k+1)*D +: D] = x1[k][D-1:0];
            iX[(3*k+2)*D +: D] = x2[k][D-1:0];
            iCOS[k*W +: W]     = cs[k][W-1:0];
            iSIN[k*W +: W]     = sn[k][W-1:0];
        end
        pushv = iVALID && iRESET;
        if (pushv)
            s = model_sample();
        @(posedge iCLK);
        #1;
        tick_no++;
        if (!iRESET) begin
            model_clear();
        end else begin
            if (pushv) begin
                s.due = tick_no + 3;
                pend.push_back(s);
            end
            m_vld = 0; eg = 0; es = 0;
            if (pend.size() > 0 && pend[0].due == tick_no) begin
                o = pend.pop_front();
                m_vld = 1; m_y = o.y; eg = o.grow; es = o.sat;
            end
            if (iNEW_STAGE && iST_ZERO) begin
                m_scale = 0; m_grow = 0; m_shift = 0; m_ovf = 0;
            end else begin
                m_ovf = m_ovf | es;
                if (iNEW_STAGE) begin
                    m_scale = m_grow | eg;
                    if ((m_grow | eg) && m_shift < (1 << S) - 1)
                        m_shift++;
                    m_grow = 0;
                end else begin
                    m_grow = m_grow | eg;
                end
            end
        end
        chk_all(tag);
    endtask

    task automatic idle(input int n);
        iVALID = 0; iNEW_STAGE = 0; iST_ZERO = 0;
        repeat (n) tick("idle");
    endtask

    task automatic frame_start();
        iVALID = 0; iNEW_STAGE = 1; iST_ZERO = 1;
        tick("frame");
        iNEW_STAGE = 0; iST_ZERO = 0;
    endtask

    task automatic push(input string tag);
        iVALID = 1;
        tick(tag);
        iVALID = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int amp;
        for (int k = 0; k < N; k++) set_lane(k, 0, 0, 0, 0, 0);
        model_clear();
        iRESET = 0;
        repeat (2) tick("reset");
        iRESET = 1;
        frame_start();

        // Plain butterfly with unit cosine
        set_lane(0, 100, 200, 0, 1024, 0);
        set_lane(1, 100, 200, 0, 1024, 0);
        push("basic");
        idle(3);
        chk("basic_const.oY", 128'(oY), 128'(pack4(300, 300, -100, -100)));
        chk("basic_const.oVALID", 128'(oVALID), 128'(1));

        // Output permutation modes
        set_lane(0, 10, 1, 0, 1024, 0);
        set_lane(1, 30, 2, 0, 1024, 0);
        iVALID = 1; iST_LAST = 1; tick("perm_last_in");
        iST_LAST = 0; i2ND_PART_SUBSEC = 1; tick("perm_sub_in");
        iST_LAST = 1; tick("perm_both_in");
        iST_LAST = 0; i2ND_PART_SUBSEC = 0; iVALID = 0;
        tick("perm");
        chk("perm_last", 128'(oY), 128'(pack4(11, 9, 32, 28)));
        tick("perm");
        chk("perm_sub", 128'(oY), 128'(pack4(32, 11, 28, 9)));
        tick("perm");
        chk("perm_both", 128'(oY), 128'(pack4(11, 9, 32, 28)));
        idle(2);

        // Saturation at both rails, sticky overflow
        set_lane(0, 65000, 65000, 0, 1024, 0);
        set_lane(1, -65000, 65000, 0, 1024, 0);
        push("sat");
        idle(3);
        chk("sat_const.oY", 128'(oY), 128'(pack4(65535, 0, 0, -65536)));
        chk("sat_const.oOVF", 128'(oOVF), 128'(1));
        idle(2);
        iNEW_STAGE = 1; tick("stage_after_sat"); iNEW_STAGE = 0;
        chk("ovf_sticky", 128'(oOVF), 128'(1));
        chk("shift_after_sat", 128'(oSHIFT), 128'(1));
        idle(1);
        frame_start();
        chk("frame_clear.oOVF", 128'(oOVF), 128'(0));
        chk("frame_clear.oSHIFT", 128'(oSHIFT), 128'(0));

        // Growth seen in the same cycle as the stage pulse, then a halved stage
        set_lane(0, 20000, 20000, 0, 1024, 0);
        set_lane(1, 0, 0, 0, 1024, 0);
        push("grow");
        idle(2);
        iNEW_STAGE = 1; tick("grow_stage"); iNEW_STAGE = 0;
        chk("grow_same_cycle.oSHIFT", 128'(oSHIFT), 128'(1));
        set_lane(0, 100, 100, 0, 1024, 0);
        set_lane(1, 100, 100, 0, 1024, 0);
        push("scaled");
        idle(3);
        chk("scaled_const.oY", 128'(oY), 128'(pack4(100, 100, 0, 0)));
        idle(1);

        // Burst with a bubble, then reset in the middle of a burst
        frame_start();
        set_lane(0, 5, 7, 3, 1024, 512); set_lane(1, -9, 4, -2, 700, -300);
        push("burst1");
        set_lane(0, -1234, 999, 77, -1024, 1024); set_lane(1, 42, -42, 42, 1024, 1024);
        push("burst2");
        idle(2);
        set_lane(0, 3000, -500, 250, 2047, -2048); set_lane(1, 1, 1, 1, 1, 1);
        push("burst3");
        idle(5);
        push("rst_burst1");
        push("rst_burst2");
        #2;
        iRESET = 0;
        #1;
        chk("async_reset.oVALID", 128'(oVALID), 128'(0));
        chk("async_reset.oY", 128'(oY), 128'(0));
        chk("async_reset.oSHIFT", 128'(oSHIFT), 128'(0));
        chk("async_reset.oOVF", 128'(oOVF), 128'(0));
        tick("in_reset");
        iRESET = 1;
        idle(6);
        push("after_reset");
        idle(4);

        // Randomized traffic with random stage pulses and frame starts
        repeat (600) begin
            case ($urandom_range(0, 2))
                0: amp = 2000;
                1: amp = 20000;
                default: amp = 65535;
            endcase
            for (int k = 0; k < N; k++)
                set_lane(k,
                         int'($urandom_range(0, 2*amp)) - amp,
                         int'($urandom_range(0, 2*amp)) - amp,
                         int'($urandom_range(0, 2*amp)) - amp,
                         int'($urandom_range(0, 4095)) - 2048,
                         int'($urandom_range(0, 4095)) - 2048);
            iVALID           = ($urandom_range(0, 9) < 6);
            iST_LAST         = ($urandom_range(0, 3) == 0);
            i2ND_PART_SUBSEC = ($urandom_range(0, 1) == 0);
            iNEW_STAGE       = ($urandom_range(0, 7) == 0);
            iST_ZERO         = ($urandom_range(0, 4) == 0);
            tick("rand");
        end
        iST_LAST = 0; i2ND_PART_SUBSEC = 0;
        idle(5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
